// File: rtl/serial_defs_pkg.sv
// Shared definitions for the serial front end and its downstream shift stages.
//   state_t          : serializer FSM state encoding
//   DEF_DW           : default word width
//   DEF_CLKS_PER_BIT : default clock cycles per emitted bit
package serial_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_DW           = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/ce_divider.sv
// Clock-enable strobe generator. Counts down from CLKS_PER_BIT-1 while running
// and pulses o_ce for one cycle when the count reaches zero, then reloads.
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   i_run     : count while high; o_ce is forced low while i_run is low
//   i_restart : reload the count (takes priority over counting)
//   o_ce      : one-cycle strobe, decoded from registers
module ce_divider
  import serial_defs::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  input  logic i_restart,
  output logic o_ce
);

  localparam int DIVW = $clog2(CLKS_PER_BIT - 1) + 1;
  localparam logic [DIVW-1:0] RELOAD = DIVW'(CLKS_PER_BIT - 1);

  logic [DIVW-1:0] div;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div <= '0;
    end else if (i_restart) begin
      div <= RELOAD;
    end else if (i_run) begin
      if (div == '0) div <= RELOAD;
      else           div <= div - 1'b1;
    end
  end

  always_comb begin
    o_ce = i_run && (div == '0);
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end. Accepts DW-bit words on a valid/ready
// handshake and emits them MSB-first, one bit per o_ce strobe.
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   i_valid   : upstream presents a word on i_data
//   i_data    : word to serialize, sampled only on accept
//   o_ready   : a word can be accepted this cycle
//   o_bit     : current serial bit (MSB of the shift register)
//   o_ce      : one-cycle strobe marking when o_bit is valid downstream
//   o_busy    : a word is in flight
module word_serializer
  import serial_defs::*;
#(
  parameter int DW           = DEF_DW,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic          o_bit,
  output logic          o_ce,
  output logic          o_busy
);

  localparam int CW = $clog2(DW - 1) + 1;

  state_t          state, state_nxt;
  logic [DW-1:0]   sreg;
  logic [CW-1:0]   bitcnt;
  logic            ce;
  logic            last_bit;
  logic            accept;

  ce_divider #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ce_divider (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_run     (state == ST_SHIFT),
    .i_restart (accept),
    .o_ce      (ce)
  );

  // The final strobe of a word doubles as the accept window for the next
  // word, so back-to-back words keep the strobe cadence unbroken.
  always_comb begin
    state_nxt = state;
    last_bit  = ce && (bitcnt == '0);
    o_ready   = (state == ST_IDLE) || last_bit;
    accept    = i_valid && o_ready;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = accept ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    o_ce   = ce;
    o_busy = (state == ST_SHIFT);
    o_bit  = (state == ST_SHIFT) ? sreg[DW-1] : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      sreg   <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sreg   <= i_data;
        bitcnt <= CW'(DW - 1);
      end else if (ce) begin
        sreg <= {sreg[DW-2:0], 1'b0};
        // Hold at zero on the final strobe instead of wrapping.
        if (bitcnt != '0) bitcnt <= bitcnt - 1'b1;
      end
    end
  end

endmodule
